// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control sequencer: FSM state encoding, opcode
// field patterns matched against the instruction register, the wait-counter
// width and the default memory timeout.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC0 = 2'd1,
        ST_EXEC1 = 2'd2,
        ST_IRQ   = 2'd3
    } state_e;

    // ir bit that marks a two-cycle instruction
    localparam int IR_LONG_BIT = 7;

    // Opcode patterns, compared against the top bits of ir
    localparam logic [1:0] OPC_MEM = 2'b10;     // ir[7:6]: memory op
    localparam logic [2:0] OPC_JMP = 3'b111;    // ir[7:5]: jump
    localparam logic [2:0] OPC_ISP = 3'b001;    // ir[7:5]: ISP group
    localparam logic [3:0] OPC_RW  = 4'b0000;   // ir[7:4]: RD/WR group
    localparam logic [3:0] OPC_LJ  = 4'b0001;   // ir[7:4]: LJ group
    localparam logic [4:0] OPC_SIG = 5'b00011;  // ir[7:3]: signal strobe

    localparam int CNT_W           = 8;
    localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Pure combinational instruction decode. All outputs are zero unless
// i_active (EXEC0 or EXEC1). SIG is only produced in the first execute
// cycle, so it is a single-cycle strobe.
// Ports:
//   i_ir     instruction register        i_cycle  0=EXEC0, 1=EXEC1
//   i_carry  ALU carry (jump condition)  i_active execute phase
//   i_abort  memory timeout this cycle (suppresses M and its derivatives)
//   o_*      decoded control lines, o_rs/o_alu fields, o_sig one-hot
// ---------------------------------------------------------------------------
module control_decode
    import ctrl_pkg::*;
#(
    parameter int SIG_SEL_W = 3
) (
    input  logic [7:0]              i_ir,
    input  logic                    i_cycle,
    input  logic                    i_carry,
    input  logic                    i_active,
    input  logic                    i_abort,
    output logic                    o_m,
    output logic                    o_s,
    output logic                    o_j,
    output logic                    o_lj,
    output logic                    o_cli,
    output logic                    o_ljr,
    output logic                    o_mw,
    output logic                    o_mc,
    output logic                    o_rd,
    output logic                    o_wr,
    output logic                    o_y,
    output logic                    o_wa,
    output logic                    o_isp,
    output logic                    o_wc,
    output logic [1:0]              o_rs,
    output logic [3:0]              o_alu,
    output logic [2**SIG_SEL_W-1:0] o_sig
);

    logic w_m;
    logic w_lj;
    logic w_isp;
    logic w_wsel;   // shared write-select term of WA/WC

    // Decode equations, gated by the execute phase
    always_comb begin
        w_m    = 1'b0;
        w_lj   = 1'b0;
        w_isp  = 1'b0;
        w_wsel = 1'b0;
        o_m    = 1'b0;
        o_s    = 1'b0;
        o_j    = 1'b0;
        o_lj   = 1'b0;
        o_cli  = 1'b0;
        o_ljr  = 1'b0;
        o_mw   = 1'b0;
        o_mc   = 1'b0;
        o_rd   = 1'b0;
        o_wr   = 1'b0;
        o_y    = 1'b0;
        o_wa   = 1'b0;
        o_isp  = 1'b0;
        o_wc   = 1'b0;
        o_rs   = 2'b00;
        o_alu  = 4'b0000;
        o_sig  = '0;
        if (i_active) begin
            // a timed-out memory cycle must not look like a memory access
            w_m    = (i_ir[7:6] == OPC_MEM) & i_cycle & ~i_abort;
            w_lj   = (i_ir[7:4] == OPC_LJ) & ~i_ir[3];
            w_isp  = (i_ir[7:5] == OPC_ISP);
            w_wsel = (i_ir[6] & ~i_ir[7]) | (i_cycle & i_ir[6] & i_ir[5]);
            o_m    = w_m;
            o_mw   = w_m & i_ir[5];
            o_mc   = i_ir[7] & ~i_cycle;
            o_j    = (i_ir[7:5] == OPC_JMP) & i_cycle & ~(i_carry & i_ir[4]);
            o_lj   = w_lj;
            o_cli  = w_lj & i_ir[1];
            o_ljr  = w_lj & i_ir[2];
            o_rd   = (i_ir[7:4] == OPC_RW) & i_ir[2];
            o_wr   = (i_ir[7:4] == OPC_RW) & i_ir[3];
            o_s    = i_ir[4];
            o_y    = i_ir[5];
            o_rs   = i_ir[1:0];
            o_alu  = i_ir[3:0];
            o_isp  = w_isp;
            o_wa   = (w_m & ~i_ir[5]) | (w_wsel & ~(i_ir[4] & ~i_ir[3]));
            o_wc   = (w_wsel | w_isp) & i_ir[4];
            if ((i_ir[7:3] == OPC_SIG) && !i_cycle) begin
                o_sig[i_ir[SIG_SEL_W-1:0]] = 1'b1;
            end else begin
                o_sig = '0;
            end
        end else begin
            o_sig = '0;
        end
    end

endmodule

// File: rtl/control_seq.sv
// ---------------------------------------------------------------------------
// control_seq
// Instruction sequencer: FETCH -> EXEC0 [-> EXEC1] -> FETCH, with optional
// IRQ entry cycle at instruction completion and a memory wait timeout.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   i_inst_valid/i_inst      instruction offer, o_inst_ready accept
//   i_carry                  ALU carry for conditional jump (EXEC1)
//   i_mem_ready              memory completion for ir[7:6]=10 ops
//   i_irq                    level interrupt request
//   o_cycle .. o_wc, o_rs, o_alu, o_sig   decoded control outputs
//   o_irq_ack                IRQ entry cycle, o_mem_err timeout pulse
//   o_ie                     interrupt enable flag
// ---------------------------------------------------------------------------
module control_seq
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int SIG_SEL_W   = 3,
    parameter int IRQ_EN      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_inst_valid,
    input  logic [7:0]              i_inst,
    output logic                    o_inst_ready,
    input  logic                    i_carry,
    input  logic                    i_mem_ready,
    input  logic                    i_irq,
    output logic                    o_cycle,
    output logic                    o_m,
    output logic                    o_s,
    output logic                    o_j,
    output logic                    o_lj,
    output logic                    o_cli,
    output logic                    o_ljr,
    output logic                    o_mw,
    output logic                    o_mc,
    output logic                    o_rd,
    output logic                    o_wr,
    output logic                    o_y,
    output logic                    o_wa,
    output logic                    o_isp,
    output logic                    o_wc,
    output logic                    o_irq_ack,
    output logic                    o_mem_err,
    output logic                    o_ie,
    output logic [1:0]              o_rs,
    output logic [3:0]              o_alu,
    output logic [2**SIG_SEL_W-1:0] o_sig
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(MEM_TIMEOUT);
    localparam logic             IRQ_ON = (IRQ_EN != 0);

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ie;
    logic             r_live;      // low until the first edge after reset release

    logic w_active;
    logic w_cycle;
    logic w_memop;
    logic w_abort;
    logic w_accept;
    logic w_done;
    logic w_ie_after;
    logic w_irq_take;
    logic w_irq_ack;
    logic w_cli;
    logic w_ljr;

    // The wait counter holds the number of not-ready EXEC1 cycles so far;
    // once it sits at the timeout value a still-missing mem_ready aborts.
    assign w_active = (r_state == ST_EXEC0) | (r_state == ST_EXEC1);
    assign w_cycle  = (r_state == ST_EXEC1);
    assign w_memop  = (r_ir[7:6] == OPC_MEM);
    assign w_abort  = w_cycle & w_memop & ~i_mem_ready & (r_cnt == TMO);
    assign w_accept = (r_state == ST_FETCH) & r_live & i_inst_valid;

    control_decode #(
        .SIG_SEL_W (SIG_SEL_W)
    ) u_decode (
        .i_ir     (r_ir),
        .i_cycle  (w_cycle),
        .i_carry  (i_carry),
        .i_active (w_active),
        .i_abort  (w_abort),
        .o_m      (o_m),
        .o_s      (o_s),
        .o_j      (o_j),
        .o_lj     (o_lj),
        .o_cli    (w_cli),
        .o_ljr    (w_ljr),
        .o_mw     (o_mw),
        .o_mc     (o_mc),
        .o_rd     (o_rd),
        .o_wr     (o_wr),
        .o_y      (o_y),
        .o_wa     (o_wa),
        .o_isp    (o_isp),
        .o_wc     (o_wc),
        .o_rs     (o_rs),
        .o_alu    (o_alu),
        .o_sig    (o_sig)
    );

    // Interrupt enable as it will be after the current cycle's CLI/LJR update
    always_comb begin
        w_ie_after = r_ie;
        if (r_state == ST_EXEC0) begin
            if (w_cli & ~w_ljr) begin
                w_ie_after = 1'b0;
            end else if (w_ljr & ~w_cli) begin
                w_ie_after = 1'b1;
            end else begin
                w_ie_after = r_ie;
            end
        end else begin
            w_ie_after = r_ie;
        end
    end

    assign w_irq_take = IRQ_ON & i_irq & w_ie_after;

    // Next-state logic; w_done marks instruction completion
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_irq_ack    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_accept) begin
                    w_state_next = ST_EXEC0;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_EXEC0: begin
                if (r_ir[IR_LONG_BIT]) begin
                    w_state_next = ST_EXEC1;
                end else begin
                    w_done = 1'b1;
                end
            end
            ST_EXEC1: begin
                if (!w_memop || i_mem_ready) begin
                    w_done = 1'b1;
                end else if (w_abort) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_EXEC1;
                end
            end
            ST_IRQ: begin
                w_irq_ack    = IRQ_ON;
                w_state_next = ST_FETCH;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
        if (w_done) begin
            w_state_next = w_irq_take ? ST_IRQ : ST_FETCH;
        end else begin
            w_irq_ack = w_irq_ack;
        end
    end

    // State, instruction register, wait counter and interrupt enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_ir    <= 8'h00;
            r_cnt   <= '0;
            r_ie    <= 1'b1;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_ir <= i_inst;
            end
            if (r_state == ST_IRQ) begin
                r_ie <= 1'b0;
            end else begin
                r_ie <= w_ie_after;
            end
            if (r_state == ST_EXEC0) begin
                r_cnt <= '0;
            end else if (w_cycle && !i_mem_ready && (r_cnt != TMO)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_inst_ready = (r_state == ST_FETCH) & r_live;
    assign o_cycle      = w_cycle;
    assign o_cli        = w_cli;
    assign o_ljr        = w_ljr;
    assign o_irq_ack    = w_irq_ack;
    assign o_mem_err    = w_abort;
    assign o_ie         = r_ie;

endmodule

// File: tb/tb_control_seq.sv
// ---------------------------------------------------------------------------
// tb_control_seq
// Stimulus computes, per instruction, the full expected cycle-by-cycle
// output sequence from the instruction rules and queues it; a monitor pops
// one expected output word every cycle and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_control_seq;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_inst_valid = 1'b0;
    logic [7:0] i_inst = 8'h00;
    logic       i_carry = 1'b0;
    logic       i_mem_ready = 1'b0;
    logic       i_irq = 1'b0;
    logic       o_inst_ready, o_cycle, o_m, o_s, o_j, o_lj, o_cli, o_ljr;
    logic       o_mw, o_mc, o_rd, o_wr, o_y, o_wa, o_isp, o_wc;
    logic       o_irq_ack, o_mem_err, o_ie;
    logic [1:0] o_rs;
    logic [3:0] o_alu;
    logic [7:0] o_sig;

    always #5 clk = ~clk;

    control_seq #(
        .MEM_TIMEOUT (T),
        .SIG_SEL_W   (3),
        .IRQ_EN      (1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_valid(i_inst_valid), .i_inst(i_inst), .o_inst_ready(o_inst_ready),
        .i_carry(i_carry), .i_mem_ready(i_mem_ready), .i_irq(i_irq),
        .o_cycle(o_cycle), .o_m(o_m), .o_s(o_s), .o_j(o_j), .o_lj(o_lj),
        .o_cli(o_cli), .o_ljr(o_ljr), .o_mw(o_mw), .o_mc(o_mc), .o_rd(o_rd),
        .o_wr(o_wr), .o_y(o_y), .o_wa(o_wa), .o_isp(o_isp), .o_wc(o_wc),
        .o_irq_ack(o_irq_ack), .o_mem_err(o_mem_err), .o_ie(o_ie),
        .o_rs(o_rs), .o_alu(o_alu), .o_sig(o_sig)
    );

    // Output word: cycle,M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,WA,ISP,WC,ack,err,ie,rdy,RS,ALU,SIG
    logic [32:0] act;
    assign act = {o_cycle, o_m, o_s, o_j, o_lj, o_cli, o_ljr, o_mw, o_mc,
                  o_rd, o_wr, o_y, o_wa, o_isp, o_wc, o_irq_ack, o_mem_err,
                  o_ie, o_inst_ready, o_rs, o_alu, o_sig};

    logic [32:0] exp_q[$];
    logic [32:0] exp_w;
    int          errors = 0;
    int          checks = 0;
    int          cyc_n  = 0;
    bit          mon_en = 1'b0;
    bit          m_ie   = 1'b1;

    localparam int K_IDLE = 0, K_FETCH = 1, K_EXEC = 2, K_IRQ = 3;

    // Reference model of one cycle's outputs from the instruction rules
    function automatic logic [32:0] model_vec(input int kind, input logic [7:0] ir,
                                              input bit cyc, input bit cy,
                                              input bit abort, input bit ie_v);
        bit m = 0, s = 0, j = 0, lj = 0, cli = 0, ljr = 0, mw = 0, mc = 0;
        bit rd = 0, wr = 0, y = 0, wa = 0, isp = 0, wc = 0, t = 0, ex = 0;
        logic [1:0] rs = 2'd0;
        logic [3:0] alu = 4'd0;
        logic [7:0] sig = 8'd0;
        int top3, top4, top5;
        top3 = int'(ir) / 32;
        top4 = int'(ir) / 16;
        top5 = int'(ir) / 8;
        ex   = (kind == K_EXEC);
        if (ex) begin
            m   = (int'(ir) / 64 == 2) && cyc && !abort;
            mw  = m && ir[5];
            mc  = ir[7] && !cyc;
            j   = (top3 == 7) && cyc && !(cy && ir[4]);
            lj  = (top4 == 1) && !ir[3];
            cli = lj && ir[1];
            ljr = lj && ir[2];
            rd  = (top4 == 0) && ir[2];
            wr  = (top4 == 0) && ir[3];
            s   = ir[4];
            y   = ir[5];
            rs  = ir[1:0];
            alu = ir[3:0];
            isp = (top3 == 1);
            t   = (ir[6] && !ir[7]) || (cyc && ir[6] && ir[5]);
            wa  = (m && !ir[5]) || (t && !(ir[4] && !ir[3]));
            wc  = (t || isp) && ir[4];
            if (top5 == 3 && !cyc) sig = 8'd1 << ir[2:0];
        end
        return {ex && cyc, m, s, j, lj, cli, ljr, mw, mc, rd, wr, y, wa, isp, wc,
                kind == K_IRQ, ex && abort, ie_v, kind == K_FETCH, rs, alu, sig};
    endfunction

    // Monitor: one expected word consumed per clock, compared mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            cyc_n++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %h, no expected entry queued", cyc_n, act);
            end else begin
                exp_w = exp_q.pop_front();
                if (act !== exp_w) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %h required %h", cyc_n, act, exp_w);
                end
            end
        end
    end

    task automatic step(input logic [32:0] v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction. d = not-ready EXEC1 cycles before mem_ready;
    // rst_at >= 0 asserts reset in that EXEC1 cycle.
    task automatic run_inst(input logic [7:0] ir, input bit cy, input bit rq,
                            input int d, input int rst_at);
        bit abort = 0;
        bit done  = 0;
        bit lj;
        i_inst_valid = 1'b1;
        i_inst       = ir;
        i_carry      = cy;
        i_irq        = rq;
        i_mem_ready  = 1'b0;
        step(model_vec(K_FETCH, 8'h00, 0, 0, 0, m_ie));
        i_inst_valid = 1'($urandom_range(0, 1));
        i_inst       = 8'($urandom);
        step(model_vec(K_EXEC, ir, 0, cy, 0, m_ie));
        lj = (ir[7:4] == 4'b0001) && !ir[3];
        if (lj && ir[1] && !ir[2]) m_ie = 1'b0;
        if (lj && ir[2] && !ir[1]) m_ie = 1'b1;
        if (ir[7] && !ir[6]) begin
            for (int k = 0; !done; k++) begin
                i_mem_ready = (k >= d);
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    m_ie  = 1'b1;
                    step(model_vec(K_IDLE, 8'h00, 0, 0, 0, 1'b1));
                    step(model_vec(K_IDLE, 8'h00, 0, 0, 0, 1'b1));
                    rst_n = 1'b1;
                    i_mem_ready = 1'b0;
                    step(model_vec(K_IDLE, 8'h00, 0, 0, 0, 1'b1));
                    return;
                end
                abort = (k == T) && (k < d);
                step(model_vec(K_EXEC, ir, 1, cy, abort, m_ie));
                done = (k >= d) || abort;
            end
        end else if (ir[7]) begin
            step(model_vec(K_EXEC, ir, 1, cy, 0, m_ie));
        end
        i_mem_ready = 1'b0;
        if (!abort && rq && m_ie) begin
            step(model_vec(K_IRQ, 8'h00, 0, 0, 0, 1'b1));
            m_ie = 1'b0;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(model_vec(K_IDLE, 8'h00, 0, 0, 0, 1'b1));
        step(model_vec(K_IDLE, 8'h00, 0, 0, 0, 1'b1));
        rst_n = 1'b1;
        step(model_vec(K_IDLE, 8'h00, 0, 0, 0, 1'b1));

        run_inst(8'h05, 0, 0, 0, -1);      // RD, ALU=5, RS=1
        run_inst(8'hE0, 0, 0, 0, -1);      // jump taken
        run_inst(8'hF0, 1, 0, 0, -1);      // jump suppressed by carry
        run_inst(8'hA0, 0, 0, 3, -1);      // 4 EXEC1 cycles with MW
        run_inst(8'hA0, 0, 1, 1000, -1);   // timeout, no IRQ after abort
        run_inst(8'h80, 0, 0, T, -1);      // ready exactly at the limit
        run_inst(8'h1E, 0, 0, 0, -1);      // SIG = 0x40
        run_inst(8'h40, 0, 1, 0, -1);      // IRQ entry, ie cleared
        run_inst(8'h14, 0, 1, 0, -1);      // LJR re-enables, IRQ again
        run_inst(8'h14, 0, 0, 0, -1);      // ie back to 1
        run_inst(8'h12, 0, 1, 0, -1);      // CLI, irq ignored
        run_inst(8'h00, 0, 1, 0, -1);      // still ignored
        run_inst(8'h16, 0, 0, 0, -1);      // CLI+LJR: ie unchanged (0)
        run_inst(8'h14, 0, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            run_inst(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, T + 2)), -1);
        end

        run_inst(8'hA0, 0, 0, 1000, 3);    // reset mid-EXEC1
        run_inst(8'h05, 0, 0, 0, -1);
        run_inst(8'hA0, 0, 0, 2, -1);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, maximum EXEC1 wait cycles for mem_ready before abort (range 1..255).
REQ-002 Parameter SIG_SEL_W, default 3, width of the signal-select field; SIG width = 2**SIG_SEL_W.
REQ-003 Parameter IRQ_EN, default 1, 0 removes interrupt entry (irq ignored, irq_ack tied 0).
REQ-004 clk  input  1  single clock, all state rises on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 inst_valid  input  1 / inst  input  8  instruction offer; inst_ready  output  1  accept (transfer when both high).
REQ-007 carry  input  1  ALU carry, sampled in EXEC1; mem_ready  input  1  memory completion; irq  input  1  level interrupt request.
REQ-008 Outputs, 1 bit each: cycle, M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC, irq_ack, mem_err, ie.
REQ-009 Outputs: RS  2  register select; ALU  4  ALU op; SIG  2**SIG_SEL_W  one-hot strobe.

Function
REQ-010 States FETCH, EXEC0, EXEC1, IRQ; reset state FETCH.
REQ-011 FETCH: inst_ready=1, all decode outputs 0; on inst_valid latch inst into ir, go EXEC0.
REQ-012 EXEC0: cycle=0, decode from ir; ir[7]=0 -> single-cycle, next FETCH (or IRQ per REQ-017); ir[7]=1 -> EXEC1.
REQ-013 EXEC1: cycle=1; if ir[7:6]=10 (memory op) hold EXEC1 until mem_ready=1, then FETCH/IRQ; else leave after one cycle.
REQ-014 Decode: M=ir7&~ir6&cycle; MW=M&ir5; MC=ir7&~cycle; J=ir[7:5]=111 & cycle & ~(carry&ir4); LJ=ir[7:4]=0001 & ~ir3; CLI=LJ&ir1; LJR=LJ&ir2; RD=ir[7:4]=0000 & ir2; WR=ir[7:4]=0000 & ir3; S=ir4; Y=ir5; RS=ir[1:0]; ALU=ir[3:0]; ISP=ir[7:5]=001.
REQ-015 WA=(M&~ir5) | (((ir6&~ir7)|(cycle&ir6&ir5)) & ~(ir4&~ir3)); WC=(((ir6&~ir7)|(cycle&ir6&ir5))|ISP) & ir4.
REQ-016 SIG = one-hot of ir[SIG_SEL_W-1:0] when ir[7:3]=00011, else 0; asserted only in EXEC0 (single-cycle pulse).
REQ-017 ie resets to 1; CLI in EXEC0 clears ie next edge; LJR in EXEC0 sets ie; CLI and LJR together -> ie unchanged.
REQ-018 At instruction completion, IRQ_EN=1 & irq=1 & ie=1 (value after that instruction's update) -> IRQ instead of FETCH.
REQ-019 IRQ: one cycle, irq_ack=1, ie cleared, decode outputs 0, then FETCH; irq held high afterward does not re-enter until ie=1.
REQ-020 Wait counter cleared on EXEC1 entry, increments each EXEC1 cycle with mem_ready=0; reaching MEM_TIMEOUT -> mem_err=1 one cycle, M/MW forced 0 that cycle, next FETCH; no IRQ entry on abort.
REQ-021 mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT -> completion wins, mem_err=0.
REQ-022 Throughput: ir[7]=0 instruction = 2 clocks (FETCH+EXEC0) with inst_valid continuously high.

Reset
REQ-023 rst_n low: state=FETCH, ir=0, counter=0, ie=1, all outputs 0 except ie=1; inst_ready rises first cycle after release.
REQ-024 Reset mid-EXEC1 or mid-IRQ abandons the operation immediately; no mem_err or irq_ack pulse produced.

Structure
REQ-025 Package ctrl_pkg holds state encoding, opcode-field localparams (ir bit positions, 0001/00011/001/111 patterns) and default MEM_TIMEOUT.
REQ-026 Pure decode (REQ-014..016) lives in sub-module control_decode (ir, cycle, carry, phase -> signals); control_seq holds FSM, ir, counter, ie.

Verification
REQ-027 Reset release, inst=0x05 offered -> FETCH, EXEC0 with RD=1, ALU=5, RS=01, cycle=0; inst_ready back high cycle 3.
REQ-028 inst=0xE0, carry=0 -> EXEC0 MC=1; EXEC1 J=1 cycle=1; repeat with inst=0xF0, carry=1 -> J=0.
REQ-029 inst=0xA0, mem_ready low 3 cycles then high -> MW=1 held 4 EXEC1 cycles, mem_err=0; mem_ready never high -> mem_err pulse after 15 cycles, then FETCH.
REQ-030 inst=0x1E (SIG sel 6) -> SIG=0x40 for exactly one cycle; inst=0x12 (CLI) -> ie=0, subsequent irq=1 ignored.
REQ-031 ie=1, irq=1 during inst=0x40 -> after EXEC0 one IRQ cycle irq_ack=1, ie=0; inst=0x14 (LJR) with irq still high -> IRQ re-entered.
REQ-032 rst_n pulsed low mid-EXEC1 of inst=0xA0 -> all outputs 0 asynchronously, ie=1, no mem_err.
